// File: rtl/equation_round_scheduler.sv
// equation_round_scheduler
//
// Runs the puzzle rounds that dismiss a sounding alarm. When the alarm fires,
// the equation units are cleared and started one at a time in round-robin
// order. Each round has a time limit counted down by a 1 Hz tick. The block
// tracks the streak of consecutive correct answers and dismisses the alarm
// once the streak reaches REQ_CORRECT.
//
// Parameters:
//   NUM_EQ       number of attached equation units (1..4)
//   ROUND_SECS   seconds allowed per round (1..127)
//   REQ_CORRECT  consecutive correct rounds needed to dismiss (1..15)
//
// Ports:
//   Clock, Reset   system clock; synchronous active-high reset
//   AlarmTrigger   alarm fired (only sampled while idle)
//   Tick           one-cycle pulse per second
//   eqDone         per-unit "answer evaluated" level
//   eqCorrect      per-unit correct flag, valid while eqDone is high
//   startEq        one-hot start to the active unit
//   eqReset        one-hot one-cycle clear to the unit about to start
//   alarmOn        puzzle session active
//   roundIdx       index of the current unit
//   secondsLeft    seconds remaining in the current round
//   streak         consecutive correct count
//   lastCorrect    result of the most recent round
//   timedOut       most recent round ended by timeout
//   dismissed      one-cycle pulse when the alarm is dismissed
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no session; waiting for AlarmTrigger
// CLEAR   | one-cycle clear of the unit selected by roundIdx
// RUN     | unit started; waiting for its answer or for the timeout
// EVAL    | score the round, advance roundIdx, update the streak
// DISMISS | one-cycle dismissal pulse, then back to IDLE

module equation_round_scheduler #(
    parameter int NUM_EQ      = 3,
    parameter int ROUND_SECS  = 30,
    parameter int REQ_CORRECT = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              AlarmTrigger,
    input  logic              Tick,
    input  logic [NUM_EQ-1:0] eqDone,
    input  logic [NUM_EQ-1:0] eqCorrect,
    output logic [NUM_EQ-1:0] startEq,
    output logic [NUM_EQ-1:0] eqReset,
    output logic              alarmOn,
    output logic [1:0]        roundIdx,
    output logic [6:0]        secondsLeft,
    output logic [3:0]        streak,
    output logic              lastCorrect,
    output logic              timedOut,
    output logic              dismissed
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        EVAL    = 3'd3,
        DISMISS = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Unit inputs are widened to four bits so roundIdx can index them for any
    // NUM_EQ without an out-of-range select.
    logic [3:0]        done_pad;
    logic [3:0]        corr_pad;
    logic              done_sel;
    logic              corr_sel;
    logic [NUM_EQ-1:0] sel_oh;
    logic [1:0]        idx_next;
    logic [3:0]        streak_inc;
    logic              timeout_now;

    assign done_pad    = 4'(eqDone);
    assign corr_pad    = 4'(eqCorrect);
    assign done_sel    = done_pad[roundIdx];
    assign corr_sel    = corr_pad[roundIdx];
    assign sel_oh      = NUM_EQ'(1) << roundIdx;
    assign idx_next    = (roundIdx == 2'(NUM_EQ - 1)) ? 2'd0 : roundIdx + 2'd1;
    assign streak_inc  = streak + 4'd1;
    assign timeout_now = Tick && (secondsLeft == 7'd1);

    always_comb begin
        state_nxt = state;
        startEq   = '0;
        eqReset   = '0;
        alarmOn   = 1'b0;
        dismissed = 1'b0;
        case (state)
            IDLE: begin
                if (AlarmTrigger) state_nxt = CLEAR;
            end
            CLEAR: begin
                eqReset   = sel_oh;
                alarmOn   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                startEq = sel_oh;
                alarmOn = 1'b1;
                if (done_sel || timeout_now) state_nxt = EVAL;
            end
            EVAL: begin
                alarmOn = 1'b1;
                if (lastCorrect && (streak_inc == 4'(REQ_CORRECT)))
                    state_nxt = DISMISS;
                else
                    state_nxt = CLEAR;
            end
            DISMISS: begin
                dismissed = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            roundIdx    <= 2'd0;
            secondsLeft <= 7'd0;
            streak      <= 4'd0;
            lastCorrect <= 1'b0;
            timedOut    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (AlarmTrigger) streak <= 4'd0;
                end
                CLEAR: begin
                    secondsLeft <= 7'(ROUND_SECS);
                end
                RUN: begin
                    // An answer in the same cycle as the final tick wins.
                    if (done_sel) begin
                        lastCorrect <= corr_sel;
                        timedOut    <= 1'b0;
                    end else if (timeout_now) begin
                        secondsLeft <= 7'd0;
                        lastCorrect <= 1'b0;
                        timedOut    <= 1'b1;
                    end else if (Tick) begin
                        secondsLeft <= secondsLeft - 7'd1;
                    end
                end
                EVAL: begin
                    roundIdx <= idx_next;
                    streak   <= lastCorrect ? streak_inc : 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_equation_round_scheduler.sv
module tb_equation_round_scheduler;

    localparam int NUM_EQ      = 3;
    localparam int ROUND_SECS  = 3;
    localparam int REQ_CORRECT = 3;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              AlarmTrigger = 1'b0;
    logic              Tick = 1'b0;
    logic [NUM_EQ-1:0] eqDone = '0;
    logic [NUM_EQ-1:0] eqCorrect = '0;
    logic [NUM_EQ-1:0] startEq;
    logic [NUM_EQ-1:0] eqReset;
    logic              alarmOn;
    logic [1:0]        roundIdx;
    logic [6:0]        secondsLeft;
    logic [3:0]        streak;
    logic              lastCorrect;
    logic              timedOut;
    logic              dismissed;

    equation_round_scheduler #(
        .NUM_EQ(NUM_EQ), .ROUND_SECS(ROUND_SECS), .REQ_CORRECT(REQ_CORRECT)
    ) dut (
        .Clock(Clock), .Reset(Reset), .AlarmTrigger(AlarmTrigger), .Tick(Tick),
        .eqDone(eqDone), .eqCorrect(eqCorrect), .startEq(startEq),
        .eqReset(eqReset), .alarmOn(alarmOn), .roundIdx(roundIdx),
        .secondsLeft(secondsLeft), .streak(streak), .lastCorrect(lastCorrect),
        .timedOut(timedOut), .dismissed(dismissed)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One record per completed round: what the round ended with and the
    // session state right after it was scored.
    typedef struct {
        int unit_oh;
        int secs;
        bit lc;
        bit to;
        int streak;
        int idx;
        bit dis;
    } rec_t;

    rec_t round_q[$];
    int   start_q[$];

    // Reference session state (round robin position and streak).
    int m_idx = 0;
    int m_streak = 0;

    function automatic int onehot(input int i);
        return 1 << i;
    endfunction

    task automatic drive(input bit rst, input bit trg, input bit tck,
                         input logic [NUM_EQ-1:0] dn, input logic [NUM_EQ-1:0] cr);
        @(negedge Clock);
        Reset = rst; AlarmTrigger = trg; Tick = tck; eqDone = dn; eqCorrect = cr;
    endtask

    // Cycle in which the scheduler must ignore every input (CLEAR/EVAL/DISMISS).
    task automatic drive_noise();
        drive(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
              NUM_EQ'($urandom), NUM_EQ'($urandom));
    endtask

    task automatic run_session(input bit directed);
        int secs, kind, k, ans_at, rst_at, rounds;
        bit ended, correct, tck, done_now;
        logic [NUM_EQ-1:0] dn, cr;
        rec_t r;
        r = '{0, 0, 1'b0, 1'b0, 0, 0, 1'b0};
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        m_streak = 0;
        rounds = 0;
        forever begin
            start_q.push_back(onehot(m_idx));
            drive_noise();
            secs    = ROUND_SECS;
            kind    = directed ? 0 : $urandom_range(0, 9);
            ans_at  = directed ? 0 : $urandom_range(0, 8);
            rst_at  = (!directed && $urandom_range(0, 11) == 0) ? $urandom_range(0, 5) : -1;
            if (rounds >= 25) rst_at = 0;
            ended = 1'b0;
            k = 0;
            while (!ended) begin
                if (k == rst_at) begin
                    drive(1'b1, $urandom_range(0, 1) == 1, 1'b1, NUM_EQ'($urandom), '0);
                    m_idx = 0;
                    m_streak = 0;
                    drive(1'b0, 1'b0, 1'b0, '0, '0);
                    return;
                end
                tck = $urandom_range(0, 2) == 0;
                dn  = NUM_EQ'($urandom) & ~NUM_EQ'(onehot(m_idx));
                cr  = NUM_EQ'($urandom);
                done_now = 1'b0;
                correct  = 1'b0;
                if (kind <= 5) begin
                    if (k == ans_at) begin
                        done_now = 1'b1;
                        correct  = directed ? 1'b1 : ($urandom_range(0, 4) != 0);
                    end
                end else if (kind == 8) begin
                    if (secs == 1) begin
                        tck = 1'b1; done_now = 1'b1; correct = 1'b1;
                    end
                end else if (kind == 9) begin
                    if (k == ans_at) begin
                        done_now = 1'b1; correct = 1'b0;
                    end
                end
                if (done_now) begin
                    dn = dn | NUM_EQ'(onehot(m_idx));
                    cr[m_idx] = correct;
                    r.secs = secs; r.lc = correct; r.to = 1'b0; ended = 1'b1;
                end else if (tck && secs == 1) begin
                    r.secs = 0; r.lc = 1'b0; r.to = 1'b1; ended = 1'b1;
                end else if (tck) begin
                    secs--;
                end
                if (ended) begin
                    r.unit_oh = onehot(m_idx);
                    m_idx     = (m_idx + 1) % NUM_EQ;
                    m_streak  = r.lc ? m_streak + 1 : 0;
                    r.streak  = m_streak;
                    r.idx     = m_idx;
                    r.dis     = (m_streak == REQ_CORRECT);
                    round_q.push_back(r);
                end
                drive(1'b0, $urandom_range(0, 5) == 0, tck, dn, cr);
                k++;
            end
            drive_noise();
            rounds++;
            if (r.dis) begin
                drive_noise();
                drive(1'b0, 1'b0, 1'b0, '0, '0);
                return;
            end
        end
    endtask

    // Monitor: samples just after each active edge, detects round starts and
    // round ends from startEq, and checks them against the queued records.
    initial begin
        logic [NUM_EQ-1:0] prev_start;
        logic [NUM_EQ-1:0] prev_clr;
        int   stage;
        int   exp_oh;
        rec_t cur;
        prev_start = '0;
        prev_clr   = '0;
        stage      = 0;
        cur        = '{0, 0, 1'b0, 1'b0, 0, 0, 1'b0};
        forever begin
            @(posedge Clock);
            #2;
            if (Reset) begin
                chk("reset_outputs", int'({startEq, eqReset, alarmOn, roundIdx, secondsLeft,
                                           streak, lastCorrect, timedOut, dismissed}), 0);
                stage = 0; prev_start = '0; prev_clr = '0;
                continue;
            end
            if (stage == 1) begin
                chk("streak_after_eval", int'(streak), cur.streak);
                chk("round_idx_after_eval", int'(roundIdx), cur.idx);
                chk("dismissed_pulse", int'(dismissed), int'(cur.dis));
                if (cur.dis) chk("alarm_off_on_dismiss", int'(alarmOn), 0);
                else         chk("clear_next_unit", int'(eqReset), onehot(cur.idx));
                stage = cur.dis ? 2 : 0;
            end else if (stage == 2) begin
                chk("idle_alarm_off", int'(alarmOn), 0);
                chk("idle_no_pulse", int'(dismissed), 0);
                chk("idle_streak_held", int'(streak), REQ_CORRECT);
                stage = 0;
            end
            if (prev_start == '0 && startEq != '0) begin
                if (start_q.size() == 0) begin
                    chk("unexpected_round_start", 1, 0);
                end else begin
                    exp_oh = start_q.pop_front();
                    chk("start_onehot", int'(startEq), exp_oh);
                    chk("clear_before_start", int'(prev_clr), exp_oh);
                    chk("seconds_loaded", int'(secondsLeft), ROUND_SECS);
                    chk("alarm_on_in_round", int'(alarmOn), 1);
                end
            end
            if (prev_start != '0 && startEq == '0) begin
                if (round_q.size() == 0) begin
                    chk("unexpected_round_end", 1, 0);
                end else begin
                    cur = round_q.pop_front();
                    chk("round_unit", int'(prev_start), cur.unit_oh);
                    chk("last_correct", int'(lastCorrect), int'(cur.lc));
                    chk("timed_out", int'(timedOut), int'(cur.to));
                    chk("seconds_at_end", int'(secondsLeft), cur.secs);
                    stage = 1;
                end
            end
            prev_start = startEq;
            prev_clr   = eqReset;
        end
    end

    initial begin
        repeat (3) drive(1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        run_session(1'b1);
        for (int s = 0; s < 60; s++) begin
            repeat ($urandom_range(0, 3))
                drive(1'b0, 1'b0, $urandom_range(0, 1) == 1, NUM_EQ'($urandom), NUM_EQ'($urandom));
            run_session(1'b0);
        end
        repeat (5) drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk("round_queue_drained", round_q.size(), 0);
        chk("start_queue_drained", start_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
